// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares one synchronous ROM read port among N_REQ draw units.
// Each returned ROM word goes back to the requester that issued the read, with a one-hot rd_valid.
module rom_read_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 12,
    parameter int ROM_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_in,
    output logic [N_REQ-1:0]            gnt,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_dout,
    output logic [N_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    idx_t                   ptr;
    idx_t                   gnt_idx;
    logic [N_REQ-1:0]       elig;
    logic                   any_elig;
    idx_t                   win_idx;
    int                     cand;
    logic [ROM_LATENCY-1:0] pipe_v;
    idx_t                   pipe_idx [ROM_LATENCY];

    // The currently granted requester is masked so it is not granted again while it drops req.
    assign elig = req & ~gnt;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        cand     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!any_elig && elig[idx_t'(cand)]) begin
                any_elig = 1'b1;
                win_idx  = idx_t'(cand);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            gnt_idx  <= '0;
            rom_addr <= '0;
            ptr      <= '0;
        end else if (any_elig) begin
            gnt      <= ONE_HOT0 << win_idx;
            gnt_idx  <= win_idx;
            rom_addr <= addr_in[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ptr      <= (win_idx == idx_t'(N_REQ-1)) ? '0 : win_idx + idx_t'(1);
        end else begin
            gnt <= '0;
        end
    end

    // Issue tracker: stage 0 holds the read the ROM sampled at the last edge; the last stage lines up with valid rom_dout.
    // NOTE: the tracker is only ROM_LATENCY entries deep, so it is reset outright to drop in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) pipe_idx[i] <= '0;
        end else begin
            for (int i = ROM_LATENCY-1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_v[0]   <= |gnt;
            pipe_idx[0] <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else if (pipe_v[ROM_LATENCY-1]) begin
            rd_valid <= ONE_HOT0 << pipe_idx[ROM_LATENCY-1];
            rd_data  <= rom_dout;
        end else begin
            rd_valid <= '0;
        end
    end

    assign busy = (|gnt) | (|pipe_v);

endmodule
